ps2_frame_decoder: RTL
======================

// Module: ps2_frame_decoder
// PURPOSE
//  Stage directly downstream of the serial-to-parallel receiver. Takes each captured 11-bit
//  PS/2 frame, checks start/parity/stop, and strips the E0 (extended) and F0 (break) prefixes.
//  Emits one key event per make/break code through a small FIFO with a valid/ready handshake.
//  Feeds the keyboard consumer logic; frame errors are flagged and counted.
// PARAMETERS
//  FIFO_DEPTH  4   event FIFO entries; power of two, >= 2
//  ERR_W       8   width of saturating frame-error counter
// PORTS
//  Clock        in   1      system clock; all state updates on posedge
//  iReset       in   1      asynchronous, active-low reset
//  i11b         in   11     captured frame; [10]=start, [9:2]=d0..d7 (d0 at bit 9), [1]=parity, [0]=stop
//  iFrameValid  in   1      1-cycle strobe: i11b holds a new frame this cycle
//  oEvent       out  10     {extended, break, scancode[7:0]} at FIFO head
//  oEventValid  out  1      FIFO not empty
//  iEventReady  in   1      consumer accepts oEvent when oEventValid & iEventReady
//  oFrameErr    out  1      1-cycle pulse: rejected frame
//  oErrCount    out  ERR_W  saturating count of rejected frames
//  oOverflow    out  1      sticky: event dropped because FIFO full; cleared only by reset
// BEHAVIOUR
//  Reset (iReset=0, async): FSM=IDLE, FIFO empty, oEvent=0, oEventValid=0, oFrameErr=0,
//   oErrCount=0, oOverflow=0. Reset mid-frame/mid-prefix discards all pending state.
//  Frame check on cycle with iFrameValid=1: good iff i11b[10]==0, i11b[0]==1 and
//   XOR(i11b[9:1])==1 (odd parity). code = {i11b[2],i11b[3],...,i11b[9]} (d7..d0).
//  Bad frame: oFrameErr=1 next cycle, oErrCount+1 (holds at all-ones), FSM->IDLE, nothing pushed.
//  FSM (updated only on good frames), states IDLE, GOT_E0, GOT_F0, GOT_E0F0:
//   code 0xE0: any state -> GOT_E0 (prefix restart).
//   code 0xF0: IDLE/GOT_F0 -> GOT_F0; GOT_E0/GOT_E0F0 -> GOT_E0F0.
//   other code: push {ext,brk,code}; ext=1 in GOT_E0/GOT_E0F0, brk=1 in GOT_F0/GOT_E0F0; ->IDLE.
//  Latency: frame strobed at edge k -> event visible (oEventValid=1) after edge k; no bypass.
//  FIFO: pop when oEventValid & iEventReady. oEvent stable while oEventValid & !iEventReady.
//   Push into full FIFO without simultaneous pop: event dropped, oOverflow set, FSM still ->IDLE.
//   Push and pop same cycle when full: both succeed, occupancy unchanged.
//   Push and pop same cycle when empty: push only (no bypass), oEventValid=1 next cycle.
//   Pointers wrap modulo FIFO_DEPTH; count register distinguishes full from empty.
//  iFrameValid is sampled only on posedge; i11b is ignored when iFrameValid=0.
//  oEvent reads 0 when FIFO empty.
// TESTING
//  1 Good frame code 0x1C (A make), ready=1 -> one event 0x01C, oEventValid one cycle, no error.
//  2 Frames E0,F0,75 -> single event 0x375 (ext=1,brk=1); frames F0,1C -> event 0x11C.
//  3 Frame with parity flipped, then stop=0, then start=1 -> 3 oFrameErr pulses, oErrCount=3,
//    no events; E0 then bad frame then 1C -> event 0x01C (prefix dropped).
//  4 ready=0, push FIFO_DEPTH+1 make codes -> first 4 held in order, 5th dropped, oOverflow=1;
//    then ready=1 -> exactly 4 events drain in order, oEventValid falls.
//  5 FIFO full, push with ready=1 same cycle -> push accepted, count stays 4, oOverflow stays 0.
//  6 Assert iReset low after E0 with events queued -> all outputs 0 immediately; next frame 1C
//    -> event 0x01C (no ext flag); 2^ERR_W+2 bad frames -> oErrCount saturates at all-ones.

Source files
------------

// File: rtl/ps2_frame_decoder_if.sv
// Frame-in / key-event-out bundle between the PS/2 receiver, the frame decoder and the keyboard consumer.
interface ps2_frame_decoder_if #(
  parameter int ERR_W = 8
);
  logic [10:0]      i11b;
  logic             iFrameValid;
  logic [9:0]       oEvent;
  logic             oEventValid;
  logic             iEventReady;
  logic             oFrameErr;
  logic [ERR_W-1:0] oErrCount;
  logic             oOverflow;

  modport slave (
    input  i11b, iFrameValid, iEventReady,
    output oEvent, oEventValid, oFrameErr, oErrCount, oOverflow
  );

  modport master (
    output i11b, iFrameValid, iEventReady,
    input  oEvent, oEventValid, oFrameErr, oErrCount, oOverflow
  );
endinterface

// File: rtl/ps2_frame_decoder.sv
// Checks PS/2 frames, strips E0/F0 prefixes and queues {ext,brk,code} key events; 1-cycle frame-to-event latency.
// Backpressure: events wait in a FIFO_DEPTH-entry FIFO; a push into a full FIFO without a pop is dropped and flagged sticky.
module ps2_frame_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input logic              Clock,
  input logic              iReset,
  ps2_frame_decoder_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_E0     = 2'd1;
  localparam logic [1:0] ST_F0     = 2'd2;
  localparam logic [1:0] ST_E0F0   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             err_q;
  logic [ERR_W-1:0] errc_q;
  logic             ovf_q;

  logic [7:0]       code;
  logic             good;
  logic             push_req;
  logic [9:0]       ev_dat;
  logic             full;
  logic             pop;
  logic             do_push;

  // d0 arrives first on the wire and sits at bit 9; code is returned as d7..d0
  always_comb begin
    code = '0;
    for (int i = 0; i < 8; i++) begin
      code[i] = bus.i11b[9-i];
    end
  end

  assign good = ~bus.i11b[10] & bus.i11b[0] & (^bus.i11b[9:1]);

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    ev_dat   = '0;
    if (bus.iFrameValid) begin
      if (!good) begin
        state_d = ST_IDLE;
      end else if (code == 8'hE0) begin
        state_d = ST_E0;
      end else if (code == 8'hF0) begin
        state_d = (state_q == ST_E0 || state_q == ST_E0F0) ? ST_E0F0 : ST_F0;
      end else begin
        push_req = 1'b1;
        ev_dat   = {(state_q == ST_E0 || state_q == ST_E0F0),
                    (state_q == ST_F0 || state_q == ST_E0F0),
                    code};
        state_d  = ST_IDLE;
      end
    end
  end

  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = (cnt_q != '0) & bus.iEventReady;
  // a pop frees a slot in the same cycle, so a full FIFO can still accept
  assign do_push = push_req & (~full | pop);

  always_ff @(posedge Clock or negedge iReset) begin
    if (!iReset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      errc_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= bus.iFrameValid & ~good;
      if (bus.iFrameValid && !good && errc_q != '1) begin
        errc_q <= errc_q + 1'b1;
      end
      if (push_req && !do_push) begin
        ovf_q <= 1'b1;
      end
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge Clock) begin
    if (do_push) begin
      mem_q[wptr_q] <= ev_dat;
    end
  end

  assign bus.oEvent      = (cnt_q != '0) ? mem_q[rptr_q] : 10'd0;
  assign bus.oEventValid = (cnt_q != '0);
  assign bus.oFrameErr   = err_q;
  assign bus.oErrCount   = errc_q;
  assign bus.oOverflow   = ovf_q;

endmodule
